// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix tile streamer: FSM state encoding,
// index width and the elaboration-time ceiling divide.
package matrix_pkg;

    // Width of every tile/beat index carried on the output sidebands.
    localparam int IDX_W = 8;

    // Streamer FSM: IDLE waits for start, RUN emits beats until the last one.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Number of tiles needed to cover `num` elements with tiles of `den`.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Nested beat / tile counter. The beat index is innermost; the order select
// chooses whether the tile column or the tile row steps next. Last flags are
// decoded from the current indices.
module tile_index_counter
    import matrix_pkg::*;
#(
    parameter int NTR    = 1,
    parameter int NTC    = 1,
    parameter int TILE_R = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic             col_order_i,
    output logic [IDX_W-1:0] beat_o,
    output logic [IDX_W-1:0] tile_r_o,
    output logic [IDX_W-1:0] tile_c_o,
    output logic             last_beat_o,
    output logic             last_tile_o
);

    localparam logic [IDX_W-1:0] BEAT_MAX = IDX_W'(TILE_R - 1);
    localparam logic [IDX_W-1:0] TR_MAX   = IDX_W'(NTR - 1);
    localparam logic [IDX_W-1:0] TC_MAX   = IDX_W'(NTC - 1);

    logic [IDX_W-1:0] beat_q, beat_d;
    logic [IDX_W-1:0] tr_q, tr_d;
    logic [IDX_W-1:0] tc_q, tc_d;
    logic             beat_wrap, tr_wrap, tc_wrap;

    assign beat_wrap = (beat_q == BEAT_MAX);
    assign tr_wrap   = (tr_q == TR_MAX);
    assign tc_wrap   = (tc_q == TC_MAX);

    // Next-index logic: clear wins, otherwise step on each accepted beat.
    always_comb begin
        beat_d = beat_q;
        tr_d   = tr_q;
        tc_d   = tc_q;
        if (clear_i) begin
            beat_d = '0;
            tr_d   = '0;
            tc_d   = '0;
        end else if (advance_i) begin
            if (!beat_wrap) begin
                beat_d = beat_q + 1'b1;
            end else begin
                beat_d = '0;
                if (!col_order_i) begin
                    if (!tc_wrap) begin
                        tc_d = tc_q + 1'b1;
                    end else begin
                        tc_d = '0;
                        tr_d = tr_wrap ? '0 : tr_q + 1'b1;
                    end
                end else begin
                    if (!tr_wrap) begin
                        tr_d = tr_q + 1'b1;
                    end else begin
                        tr_d = '0;
                        tc_d = tc_wrap ? '0 : tc_q + 1'b1;
                    end
                end
            end
        end
    end

    // Index registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
            tr_q   <= '0;
            tc_q   <= '0;
        end else begin
            beat_q <= beat_d;
            tr_q   <= tr_d;
            tc_q   <= tc_d;
        end
    end

    assign beat_o      = beat_q;
    assign tile_r_o    = tr_q;
    assign tile_c_o    = tc_q;
    assign last_beat_o = beat_wrap;
    assign last_tile_o = beat_wrap && tr_wrap && tc_wrap;

endmodule

// File: rtl/matrix_tile_streamer.sv
// Streams a flat row-major matrix out as tiles, one tile row (or tile column
// when transposing) per beat, with out-of-range elements replaced by PAD_VALUE.
//
// Handshake: a beat transfers on a cycle where out_valid && out_ready. While
// out_valid is high and out_ready is low, out_data and every out_* sideband
// hold their value; out_valid never drops until the beat is accepted.
module matrix_tile_streamer
    import matrix_pkg::*;
#(
    parameter int                    ROWS       = 128,
    parameter int                    COLS       = 128,
    parameter int                    TILE_R     = 64,
    parameter int                    TILE_C     = 64,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH*ROWS*COLS-1:0] matrix_flat,
    input  logic                            start,
    input  logic                            mode_col_order,
    input  logic                            mode_transpose,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH*TILE_C-1:0]    out_data,
    output logic [7:0]                      out_tile_r,
    output logic [7:0]                      out_tile_c,
    output logic [7:0]                      out_beat,
    output logic                            out_last_beat,
    output logic                            out_last_tile,
    output logic                            done,
    output state_e                          dbg_state
);

    localparam int NTR = ceil_div(ROWS, TILE_R);
    localparam int NTC = ceil_div(COLS, TILE_C);

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic   col_order_q, transpose_q;
    logic   start_acc, fire;
    logic   cnt_last_beat, cnt_last_tile;

    assign start_acc = start && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN);
    assign fire      = out_valid && out_ready;

    tile_index_counter #(
        .NTR    (NTR),
        .NTC    (NTC),
        .TILE_R (TILE_R)
    ) u_cnt (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (start_acc),
        .advance_i   (fire),
        .col_order_i (col_order_q),
        .beat_o      (out_beat),
        .tile_r_o    (out_tile_r),
        .tile_c_o    (out_tile_c),
        .last_beat_o (cnt_last_beat),
        .last_tile_o (cnt_last_tile)
    );

    // FSM next state: leave IDLE on start, return once the final beat is taken.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (fire && cnt_last_tile) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, done pulse and stream modes captured when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            col_order_q <= 1'b0;
            transpose_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (start_acc) begin
                col_order_q <= mode_col_order;
                transpose_q <= mode_transpose;
            end
        end
    end

    // Lane gather: pick each element from the flat matrix, pad outside bounds.
    always_comb begin
        int base_r;
        int base_c;
        int row_v;
        int col_v;
        base_r   = int'(out_tile_r) * TILE_R;
        base_c   = int'(out_tile_c) * TILE_C;
        row_v    = 0;
        col_v    = 0;
        out_data = '0;
        for (int k = 0; k < TILE_C; k++) begin
            row_v = transpose_q ? base_r + k : base_r + int'(out_beat);
            col_v = transpose_q ? base_c + int'(out_beat) : base_c + k;
            if (out_valid) begin
                if (row_v < ROWS && col_v < COLS)
                    out_data[k*DATA_WIDTH +: DATA_WIDTH] =
                        matrix_flat[(row_v*COLS + col_v)*DATA_WIDTH +: DATA_WIDTH];
                else
                    out_data[k*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
            end
        end
    end

    assign out_last_beat = out_valid && cnt_last_beat;
    assign out_last_tile = out_valid && cnt_last_tile;
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_matrix_tile_streamer.sv
// Directed bench for matrix_tile_streamer: an 8x8 instance (A) and a padded
// 6x10 instance (B), both with 4x4 tiles and 16-bit elements, M[i][j]=i*256+j.
module tb_matrix_tile_streamer;
    import matrix_pkg::*;

    localparam int W = 90; // {tile_r, tile_c, beat, last_beat, last_tile, data[63:0]}

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT wiring ----------------
    logic [1023:0] mat_a;
    logic [959:0]  mat_b;
    logic          start_a, start_b, mode_col_order, mode_transpose, ready;
    logic          a_busy, a_valid, a_lb, a_lt, a_done;
    logic          b_busy, b_valid, b_lb, b_lt, b_done;
    logic [63:0]   a_data, b_data;
    logic [7:0]    a_tr, a_tc, a_beat, b_tr, b_tc, b_beat;
    state_e        a_state, b_state;

    matrix_tile_streamer #(
        .ROWS(8), .COLS(8), .TILE_R(4), .TILE_C(4), .DATA_WIDTH(16), .PAD_VALUE(16'd0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .matrix_flat(mat_a), .start(start_a),
        .mode_col_order(mode_col_order), .mode_transpose(mode_transpose),
        .busy(a_busy), .out_valid(a_valid), .out_ready(ready), .out_data(a_data),
        .out_tile_r(a_tr), .out_tile_c(a_tc), .out_beat(a_beat),
        .out_last_beat(a_lb), .out_last_tile(a_lt), .done(a_done), .dbg_state(a_state)
    );

    matrix_tile_streamer #(
        .ROWS(6), .COLS(10), .TILE_R(4), .TILE_C(4), .DATA_WIDTH(16), .PAD_VALUE(16'd0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .matrix_flat(mat_b), .start(start_b),
        .mode_col_order(mode_col_order), .mode_transpose(mode_transpose),
        .busy(b_busy), .out_valid(b_valid), .out_ready(ready), .out_data(b_data),
        .out_tile_r(b_tr), .out_tile_c(b_tc), .out_beat(b_beat),
        .out_last_beat(b_lb), .out_last_tile(b_lt), .done(b_done), .dbg_state(b_state)
    );

    // Observed signals of whichever instance is selected.
    logic          sel;
    logic          obs_busy, obs_valid, obs_done;
    logic [W-1:0]  obs_pack;
    logic [0:0]    obs_state;
    always_comb begin
        obs_busy  = sel ? b_busy  : a_busy;
        obs_valid = sel ? b_valid : a_valid;
        obs_done  = sel ? b_done  : a_done;
        obs_state = sel ? b_state : a_state;
        obs_pack  = sel ? {b_tr, b_tc, b_beat, b_lb, b_lt, b_data}
                        : {a_tr, a_tc, a_beat, a_lb, a_lt, a_data};
    end

    // ---------------- scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] ref_q[$];
    int           done_cycle;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference beat for a 4x4-tiled matrix holding M[i][j]=i*256+j.
    function automatic logic [W-1:0] model_beat(input int rows, input int cols, input int tr,
                                                 input int tc, input int b, input bit transpose,
                                                 input bit lt);
        logic [63:0] d;
        int row, col;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            row = tr * 4 + (transpose ? k : b);
            col = tc * 4 + (transpose ? b : k);
            if (row < rows && col < cols) d[k*16 +: 16] = 16'(row * 256 + col);
        end
        return {8'(tr), 8'(tc), 8'(b), (b == 3), lt, d};
    endfunction

    task automatic fill_expected(input int rows, input int cols, input bit order, input bit transpose);
        int ntr, ntc, n_out, n_in, tr, tc;
        bit lt;
        ntr   = (rows + 3) / 4;
        ntc   = (cols + 3) / 4;
        n_out = order ? ntc : ntr;
        n_in  = order ? ntr : ntc;
        exp_q.delete();
        for (int o = 0; o < n_out; o++)
            for (int i = 0; i < n_in; i++)
                for (int b = 0; b < 4; b++) begin
                    tr = order ? i : o;
                    tc = order ? o : i;
                    lt = (o == n_out - 1) && (i == n_in - 1) && (b == 3);
                    exp_q.push_back(model_beat(rows, cols, tr, tc, b, transpose, lt));
                end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue start on the selected instance, then consume every expected beat.
    task automatic run_stream(input string tag, input bit rand_ready, input int budget);
        int cyc;
        bit fire;
        got_q.delete();
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 1;
        while (exp_q.size() > 0 && cyc <= budget) begin
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            check({tag, " valid"}, obs_valid, 1);
            check({tag, " busy"}, obs_busy, 1);
            check({tag, " beat"}, obs_pack, exp_q[0]);
            fire = obs_valid && ready;
            if (fire) begin
                got_q.push_back(obs_pack);
                void'(exp_q.pop_front());
            end
            step();
            cyc++;
        end
        ready = 1'b1;
        check({tag, " beats left at budget"}, exp_q.size(), 0);
        done_cycle = cyc;
        check({tag, " done"}, obs_done, 1);
        check({tag, " busy at done"}, obs_busy, 0);
        check({tag, " valid at done"}, obs_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) mat_a[(i*8 + j)*16 +: 16] = 16'(i*256 + j);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 10; j++) mat_b[(i*10 + j)*16 +: 16] = 16'(i*256 + j);
        sel = 1'b0; rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        mode_col_order = 1'b0; mode_transpose = 1'b0; ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state of both instances.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("reset valid", obs_valid, 0);
            check("reset busy", obs_busy, 0);
            check("reset done", obs_done, 0);
            check("reset outputs", obs_pack, 0);
            check("reset state", obs_state, ST_IDLE);
        end
        sel = 1'b0;
        step();

        // 8x8, row-wise tile order, ready held high.
        fill_expected(8, 8, 1'b0, 1'b0);
        run_stream("a_ord0", 1'b0, 40);
        check("a_ord0 count", got_q.size(), 16);
        check("a_ord0 done cycle", done_cycle, 17);
        check("a_ord0 beat4", got_q[4], {8'd0, 8'd1, 8'd0, 1'b0, 1'b0, 64'h0007_0006_0005_0004});
        check("a_ord0 beat15 last", got_q[15][W-25:W-26], 2'b11);
        ref_q = got_q;

        // Column-wise tile order, started in the done cycle of the previous stream.
        mode_col_order = 1'b1;
        fill_expected(8, 8, 1'b1, 1'b0);
        run_stream("a_ord1", 1'b0, 40);
        check("a_ord1 count", got_q.size(), 16);
        check("a_ord1 beat4", got_q[4], {8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 64'h0403_0402_0401_0400});

        // Transposed beats.
        mode_col_order = 1'b0;
        mode_transpose = 1'b1;
        fill_expected(8, 8, 1'b0, 1'b1);
        run_stream("a_tr", 1'b0, 40);
        check("a_tr beat1", got_q[1], {8'd0, 8'd0, 8'd1, 1'b0, 1'b0, 64'h0301_0201_0101_0001});

        // Padded 6x10 matrix: 2x3 tiles.
        mode_transpose = 1'b0;
        sel = 1'b1;
        fill_expected(6, 10, 1'b0, 1'b0);
        run_stream("b_pad", 1'b0, 60);
        check("b_pad count", got_q.size(), 24);
        check("b_pad tile12 beat1", got_q[21], {8'd1, 8'd2, 8'd1, 1'b0, 1'b0, 64'h0000_0000_0509_0508});
        check("b_pad tile12 beat2 data", got_q[22][63:0], 64'd0);
        check("b_pad tile12 beat3 data", got_q[23][63:0], 64'd0);
        check("b_pad final flags", got_q[23][W-25:W-26], 2'b11);

        // Random back-pressure: same sequence as the ready-high run.
        sel = 1'b0;
        step();
        fill_expected(8, 8, 1'b0, 1'b0);
        run_stream("a_stall", 1'b1, 300);
        check("a_stall count", got_q.size(), ref_q.size());
        for (int i = 0; i < 16; i++) check("a_stall vs ready run", got_q[i], ref_q[i]);

        // Start during RUN is ignored; reset at beat 5 aborts the stream.
        step();
        ready = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();                       // beat 1 visible
        start_a = 1'b1;
        step();                       // beat 2 visible, start ignored
        start_a = 1'b0;
        check("ignored start beat", a_beat, 2);
        check("ignored start tile_c", a_tc, 0);
        step();
        step();
        step();                       // overall beat 5: tile (0,1) beat 1
        check("beat5 tile_c", a_tc, 1);
        check("beat5 beat", a_beat, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst valid", a_valid, 0);
        check("midrst busy", a_busy, 0);
        check("midrst done", a_done, 0);
        check("midrst outputs", obs_pack, 0);
        step();
        check("midrst stays idle", a_valid, 0);
        fill_expected(8, 8, 1'b0, 1'b0);
        run_stream("a_restart", 1'b0, 40);
        check("a_restart count", got_q.size(), 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
